// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and helpers for the EX-stage branch resolve unit.
// Default build has no perf counters; define BRU_PERF_CNT_EN to build them.
package branch_resolve_unit_pkg;

    localparam int WORD_WIDTH     = 32;
    localparam int SHADOW_CYC_DEF = 2;
    localparam int PERF_CNT_W_DEF = 32;

    typedef enum logic [0:0] {
        BRU_IDLE   = 1'b0,
        BRU_SHADOW = 1'b1
    } bru_state_e;

    // Direction wrong, or taken both ways but to a different target.
    function automatic logic bru_mispredict(input logic taken_eff,
                                            input logic pred_taken,
                                            input logic target_match);
        return (taken_eff != pred_taken) | (taken_eff & pred_taken & ~target_match);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Resolution bus between the EX stage (master) and the branch resolve unit (slave),
// including the predictor update / fetch redirect returns and perf counters.
interface branch_resolve_unit_if #(
    parameter int W     = 32,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             res_valid;
    logic             res_is_cond;
    logic [W-1:0]     res_pc;
    logic             res_pred_taken;
    logic [W-1:0]     res_pred_addr;
    logic             res_taken;
    logic [W-1:0]     res_target;
    logic             upd;
    logic             add_else_minus;
    logic [W-1:0]     upd_src_pc;
    logic             flush;
    logic [W-1:0]     flush_addr;
    logic             in_shadow;
    logic [CNT_W-1:0] perf_branches;
    logic [CNT_W-1:0] perf_mispred;

    modport master (
        output stall, res_valid, res_is_cond, res_pc, res_pred_taken,
               res_pred_addr, res_taken, res_target,
        input  upd, add_else_minus, upd_src_pc, flush, flush_addr, in_shadow,
               perf_branches, perf_mispred
    );

    modport slave (
        input  stall, res_valid, res_is_cond, res_pc, res_pred_taken,
               res_pred_addr, res_taken, res_target,
        output upd, add_else_minus, upd_src_pc, flush, flush_addr, in_shadow,
               perf_branches, perf_mispred
    );
endinterface

// File: rtl/branch_resolve_unit_shadow_ctr.sv
// Loadable down-counter timing the post-redirect shadow; freezes on stall,
// reports zero and last-count (about to expire) flags.
module bru_shadow_ctr #(
    parameter int CTR_W    = 2,
    parameter int LOAD_VAL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_freeze,
    output logic o_zero,
    output logic o_last
);
    logic [CTR_W-1:0] r_count;

    // Load wins over freeze so a redirect during stall still arms the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= {CTR_W{1'b0}};
        end else if (i_load) begin
            r_count <= CTR_W'(LOAD_VAL);
        end else if (!i_freeze && (r_count != {CTR_W{1'b0}})) begin
            r_count <= r_count - CTR_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {CTR_W{1'b0}});
    assign o_last = (r_count == CTR_W'(1));
endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: trains the fetch predictor, redirects fetch on mispredict
// and squashes wrong-path resolutions. Optional perf counters under BRU_PERF_CNT_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int W          = WORD_WIDTH,
    parameter int SHADOW_CYC = SHADOW_CYC_DEF,
    parameter int CNT_W      = PERF_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus
);
    localparam int CTR_W = (SHADOW_CYC < 2) ? 1 : $clog2(SHADOW_CYC + 1);

    bru_state_e   r_state;
    logic         r_upd;
    logic         r_add_else_minus;
    logic [W-1:0] r_upd_src_pc;
    logic         r_flush;
    logic [W-1:0] r_flush_addr;
    logic         r_in_shadow;

    logic         w_accept;
    logic         w_taken_eff;
    logic [W-1:0] w_seq;
    logic         w_mispred;
    logic         w_enter_shadow;
    logic         w_ctr_zero;
    logic         w_ctr_last;

    assign w_accept       = bus.res_valid & ~bus.stall & (r_state == BRU_IDLE);
    assign w_taken_eff    = bus.res_is_cond ? bus.res_taken : 1'b1;
    assign w_seq          = bus.res_pc + W'(4);
    assign w_mispred      = bru_mispredict(w_taken_eff, bus.res_pred_taken,
                                           bus.res_target == bus.res_pred_addr);
    assign w_enter_shadow = w_accept & w_mispred & (SHADOW_CYC != 0);

    bru_shadow_ctr #(
        .CTR_W    (CTR_W),
        .LOAD_VAL (SHADOW_CYC)
    ) u_shadow_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_enter_shadow),
        .i_freeze (bus.stall),
        .o_zero   (w_ctr_zero),
        .o_last   (w_ctr_last)
    );

    // Resolution FSM and all registered outputs; in_shadow tracks the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= BRU_IDLE;
            r_upd            <= 1'b0;
            r_add_else_minus <= 1'b0;
            r_upd_src_pc     <= {W{1'b0}};
            r_flush          <= 1'b0;
            r_flush_addr     <= {W{1'b0}};
            r_in_shadow      <= 1'b0;
        end else begin
            r_upd   <= w_accept;
            r_flush <= w_accept & w_mispred;
            if (w_accept) begin
                r_add_else_minus <= w_taken_eff;
                r_upd_src_pc     <= bus.res_pc;
            end else begin
                r_add_else_minus <= r_add_else_minus;
                r_upd_src_pc     <= r_upd_src_pc;
            end
            if (w_accept && w_mispred) begin
                r_flush_addr <= w_taken_eff ? bus.res_target : w_seq;
            end else begin
                r_flush_addr <= r_flush_addr;
            end
            case (r_state)
                BRU_IDLE: begin
                    if (w_enter_shadow) begin
                        r_state     <= BRU_SHADOW;
                        r_in_shadow <= 1'b1;
                    end else begin
                        r_state     <= BRU_IDLE;
                        r_in_shadow <= 1'b0;
                    end
                end
                BRU_SHADOW: begin
                    // Zero flag is a fallback exit should the counter ever be empty here.
                    if (!bus.stall && (w_ctr_last || w_ctr_zero)) begin
                        r_state     <= BRU_IDLE;
                        r_in_shadow <= 1'b0;
                    end else begin
                        r_state     <= BRU_SHADOW;
                        r_in_shadow <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= BRU_IDLE;
                    r_in_shadow <= 1'b0;
                end
            endcase
        end
    end

    assign bus.upd            = r_upd;
    assign bus.add_else_minus = r_add_else_minus;
    assign bus.upd_src_pc     = r_upd_src_pc;
    assign bus.flush          = r_flush;
    assign bus.flush_addr     = r_flush_addr;
    assign bus.in_shadow      = r_in_shadow;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_branches;
    logic [CNT_W-1:0] r_perf_mispred;

    // Event counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_branches <= {CNT_W{1'b0}};
            r_perf_mispred  <= {CNT_W{1'b0}};
        end else begin
            r_perf_branches <= r_perf_branches + (w_accept ? CNT_W'(1) : CNT_W'(0));
            r_perf_mispred  <= r_perf_mispred + ((w_accept && w_mispred) ? CNT_W'(1) : CNT_W'(0));
        end
    end

    assign bus.perf_branches = r_perf_branches;
    assign bus.perf_mispred  = r_perf_mispred;
`else
    assign bus.perf_branches = {CNT_W{1'b0}};
    assign bus.perf_mispred  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios then random traffic,
// compared each cycle against a cycle-level behavioural model.
module tb_branch_resolve_unit;
    localparam int W          = 32;
    localparam int SHADOW_CYC = 2;
    localparam int CNT_W      = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.W(W), .CNT_W(CNT_W)) bus ();

    branch_resolve_unit #(.W(W), .SHADOW_CYC(SHADOW_CYC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_left = 0;
    logic        m_upd = 1'b0, m_flush = 1'b0, m_aem = 1'b0, m_shadow = 1'b0;
    logic [31:0] m_src = 32'h0, m_faddr = 32'h0;
    logic [31:0] m_pb = 32'h0, m_pm = 32'h0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic v, input logic c,
                              input logic [31:0] pc, input logic pt, input logic [31:0] pa,
                              input logic t, input logic [31:0] tg);
        logic tk;
        logic mp;
        if (r) begin
            m_left = 0; m_upd = 0; m_flush = 0; m_aem = 0;
            m_src = 0; m_faddr = 0; m_pb = 0; m_pm = 0;
        end else begin
            m_upd = 0;
            m_flush = 0;
            if (s) begin
                // stalled: nothing moves
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (v) begin
                tk = c ? t : 1'b1;
                mp = (tk != pt) || (tk && pt && (tg != pa));
                m_upd = 1;
                m_aem = tk;
                m_src = pc;
                m_pb  = m_pb + 1;
                if (mp) begin
                    m_flush = 1;
                    m_faddr = tk ? tg : pc + 32'd4;
                    m_pm    = m_pm + 1;
                    m_left  = SHADOW_CYC;
                end
            end
        end
        m_shadow = (m_left > 0);
    endtask

    task automatic check_outputs();
        check_val("upd", {31'b0, bus.upd}, {31'b0, m_upd});
        check_val("flush", {31'b0, bus.flush}, {31'b0, m_flush});
        check_val("in_shadow", {31'b0, bus.in_shadow}, {31'b0, m_shadow});
        check_val("upd_src_pc", bus.upd_src_pc, m_src);
        check_val("flush_addr", bus.flush_addr, m_faddr);
        if (m_upd) check_val("add_else_minus", {31'b0, bus.add_else_minus}, {31'b0, m_aem});
`ifdef BRU_PERF_CNT_EN
        check_val("perf_branches", bus.perf_branches, m_pb);
        check_val("perf_mispred", bus.perf_mispred, m_pm);
`else
        check_val("perf_branches", bus.perf_branches, 32'h0);
        check_val("perf_mispred", bus.perf_mispred, 32'h0);
`endif
    endtask

    task automatic step(input logic r, input logic s, input logic v, input logic c,
                        input logic [31:0] pc, input logic pt, input logic [31:0] pa,
                        input logic t, input logic [31:0] tg);
        rst                = r;
        bus.stall          = s;
        bus.res_valid      = v;
        bus.res_is_cond    = c;
        bus.res_pc         = pc;
        bus.res_pred_taken = pt;
        bus.res_pred_addr  = pa;
        bus.res_taken      = t;
        bus.res_target     = tg;
        @(posedge clk);
        model_edge(r, s, v, c, pc, pt, pa, t, tg);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        // reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h50, 1'b0, 32'h0, 1'b1, 32'h60);
        check_val("reset_upd", {31'b0, bus.upd}, 32'h0);
        check_val("reset_flush_addr", bus.flush_addr, 32'h0);

        // 1: correctly predicted not-taken
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h200);
        check_val("t1_upd", {31'b0, bus.upd}, 32'h1);
        check_val("t1_src", bus.upd_src_pc, 32'h100);
        idle();

        // 2: predicted NT, taken
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
        check_val("t2_flush_addr", bus.flush_addr, 32'h200);
        check_val("t2_aem", {31'b0, bus.add_else_minus}, 32'h1);
        idle();
        check_val("t2_shadow_c2", {31'b0, bus.in_shadow}, 32'h1);
        idle();
        check_val("t2_shadow_c3", {31'b0, bus.in_shadow}, 32'h0);

        // 3: predicted T, not taken -> sequential pc
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h200);
        check_val("t3_flush_addr", bus.flush_addr, 32'h104);
        idle(); idle();

        // 4: jump to wrong target, then two wrong-path resolutions squashed, third accepted
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h180, 1'b1, 32'h300, 1'b0, 32'h340);
        check_val("t4_flush_addr", bus.flush_addr, 32'h340);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h340, 1'b0, 32'h0, 1'b1, 32'h500);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h344, 1'b0, 32'h0, 1'b1, 32'h600);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h348, 1'b0, 32'h0, 1'b0, 32'h0);
        check_val("t4_after_shadow_upd", {31'b0, bus.upd}, 32'h1);

        // 5: stall blocks accept and freezes the shadow
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h800);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h800);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h404, 1'b0, 32'h0, 1'b1, 32'h0);
        check_val("t5_frozen_shadow", {31'b0, bus.in_shadow}, 32'h1);
        idle(); idle(); idle();

        // 6: pc wrap, perf, reset mid-shadow
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 32'h40);
        check_val("t6_wrap_addr", bus.flush_addr, 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h20);
        check_val("t6_rst_shadow", {31'b0, bus.in_shadow}, 32'h0);
        idle();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] pc, tg, pa;
            pc = $urandom() & 32'hFFFF_FFFC;
            tg = $urandom() & 32'hFFFF_FFFC;
            pa = ($urandom_range(0, 1) == 0) ? tg : ($urandom() & 32'hFFFF_FFFC);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
                 pc, ($urandom_range(0, 1) == 1), pa, ($urandom_range(0, 1) == 1), tg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
